// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source {tag,value} FIFOs feeding one registered broadcast bus.
// Define CDB_RR_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module cdb_arbiter #(
  parameter int NSRC   = 3,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2,
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clear,
  input  logic [NSRC-1:0]          src_valid,
  output logic [NSRC-1:0]          src_ready,
  input  logic [NSRC*TAG_W-1:0]    src_tag,
  input  logic [NSRC*DATA_W-1:0]   src_value,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_value,
  output logic [SRC_W-1:0]         cdb_src
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [TAG_W-1:0]  r_tagMem [NSRC][DEPTH];
  logic [DATA_W-1:0] r_valMem [NSRC][DEPTH];
  logic [PTR_W-1:0]  r_wrPtr  [NSRC];
  logic [PTR_W-1:0]  r_rdPtr  [NSRC];
  logic [CNT_W-1:0]  r_count  [NSRC];

  logic              r_cdbValid;
  logic [TAG_W-1:0]  r_cdbTag;
  logic [DATA_W-1:0] r_cdbValue;
  logic [SRC_W-1:0]  r_cdbSrc;
`ifdef CDB_RR_EN
  logic [SRC_W-1:0]  r_rrLast;
  logic [SRC_W-1:0]  w_idx;
`endif

  logic [NSRC-1:0]   w_ready;
  logic [NSRC-1:0]   w_push;
  logic [NSRC-1:0]   w_pop;
  logic [NSRC-1:0]   w_nonEmpty;
  logic              w_grantValid;
  logic [SRC_W-1:0]  w_grantIdx;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at the registered count, so a full FIFO stays not-ready even while it pops.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_nonEmpty[i] = (r_count[i] != '0);
      w_ready[i]    = rdy && !clear && (r_count[i] != FULL);
      w_push[i]     = src_valid[i] && w_ready[i];
    end
  end

  assign src_ready = w_ready;

  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
`ifdef CDB_RR_EN
    w_idx        = '0;
    for (int k = 1; k <= NSRC; k++) begin
      w_idx = SRC_W'((int'(r_rrLast) + k) % NSRC);
      if (!w_grantValid && w_nonEmpty[w_idx]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_idx;
      end
    end
`else
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_nonEmpty[i]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = SRC_W'(i);
      end
    end
`endif
    for (int i = 0; i < NSRC; i++) begin
      w_pop[i] = w_grantValid && (w_grantIdx == SRC_W'(i));
    end
  end

  // Storage needs no reset: an entry is only read after its count says it was written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (!rst && w_push[i]) begin
        r_tagMem[i][r_wrPtr[i]] <= src_tag[i*TAG_W +: TAG_W];
        r_valMem[i][r_wrPtr[i]] <= src_value[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_count[i] <= '0;
      end
      r_cdbValid <= 1'b0;
      r_cdbTag   <= '0;
      r_cdbValue <= '0;
      r_cdbSrc   <= '0;
`ifdef CDB_RR_EN
      r_rrLast   <= SRC_W'(NSRC - 1);
`endif
    end else if (rdy) begin
      if (clear) begin
        for (int i = 0; i < NSRC; i++) begin
          r_wrPtr[i] <= '0;
          r_rdPtr[i] <= '0;
          r_count[i] <= '0;
        end
        r_cdbValid <= 1'b0;
      end else begin
        for (int i = 0; i < NSRC; i++) begin
          if (w_push[i]) r_wrPtr[i] <= nextPtr(r_wrPtr[i]);
          if (w_pop[i])  r_rdPtr[i] <= nextPtr(r_rdPtr[i]);
          r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
        end
        r_cdbValid <= w_grantValid;
        if (w_grantValid) begin
          r_cdbTag   <= r_tagMem[w_grantIdx][r_rdPtr[w_grantIdx]];
          r_cdbValue <= r_valMem[w_grantIdx][r_rdPtr[w_grantIdx]];
          r_cdbSrc   <= w_grantIdx;
`ifdef CDB_RR_EN
          r_rrLast   <= w_grantIdx;
`endif
        end
      end
    end
  end

  assign cdb_valid = r_cdbValid;
  assign cdb_tag   = r_cdbTag;
  assign cdb_value = r_cdbValue;
  assign cdb_src   = r_cdbSrc;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It buffers completed results from the execution sources (RS/ALU, SLB load port, spare third source) and grants exactly one of them per cycle onto a registered broadcast bus. That bus drives the wakeup/writeback inputs of the RS, SLB and ROB. It replaces the per-source point-to-point result wiring with a single serialized result stream.

## Interface
- NSRC, 3: number of result sources; index 0 = RS/ALU, 1 = SLB load, 2 = spare.
- DATA_W, 32: result value width.
- TAG_W, 4: ROB tag width.
- DEPTH, 2: per-source holding FIFO depth; power of two, ≥1.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; low = freeze.
- clear  in  1  misprediction flush (Clear_flag).
- src_valid  in  NSRC  result offered by source i.
- src_ready  out  NSRC  source i FIFO can accept.
- src_tag  in  NSRC*TAG_W  ROB tag per source; slice i = [i*TAG_W +: TAG_W].
- src_value  in  NSRC*DATA_W  result value per source.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast ROB tag.
- cdb_value  out  DATA_W  broadcast value.
- cdb_src  out  clog2(NSRC)  index of the granted source.

## Operation
- Per source: circular FIFO of {tag, value} with DEPTH entries, read/write pointers, and a count of width clog2(DEPTH)+1.
- `src_ready[i] = rdy && !clear && count_i != DEPTH`. It is combinational from registered count only, so a full FIFO is not ready even in a cycle where it pops.
- Push: `src_valid[i] && src_ready[i]` at the edge.
- Grant: one non-empty FIFO is chosen per cycle, using pre-edge counts. The selected head is popped and loaded into the cdb output registers.
- If no FIFO is non-empty, cdb_valid <= 0 and tag/value/src are held.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance. This is legal only when the FIFO was not full.
- Pointers wrap modulo DEPTH.
- A result is never dropped or duplicated; order within one source is preserved.
- clear (with rdy high): all counts and pointers <= 0, cdb_valid <= 0. Pushes and grants are suppressed that edge. The round-robin pointer is unchanged.
- rdy low: no register changes at all. Outputs hold their value, except src_ready, which is 0.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, all FIFOs empty, rr_last=NSRC-1.
- src_ready is therefore 1 on all sources after reset, provided rdy is high.
- Latency: a result pushed at edge E into an otherwise idle arbiter is granted at edge E+1. cdb_valid is then high during the cycle after E+1. Latency is 2 edges, with no bypass.
- Throughput: one broadcast per cycle in aggregate.
- Per source, DEPTH=2 sustains one push per cycle while that source is granted every cycle.
- cdb_valid is a one-cycle pulse per granted result. There is no backpressure from consumers.
- Reset has priority over clear; clear has priority over normal operation. A reset or clear mid-stream discards all buffered results.

## Configuration
- `CDB_RR_EN` defined: round-robin arbitration. The search starts at rr_last+1 (mod NSRC), and the first non-empty FIFO wins. rr_last <= granted index on every grant.
- Not defined: fixed priority, lowest index wins (RS/ALU over SLB over spare). rr_last is absent.

## Test plan
- Reset, then push tag=3 value=0x11 on src0 at edge 1 -> cdb_valid high after edge 2 with tag=3, value=0x11, src=0; idle afterwards, cdb_valid=0.
- Push src0 (tag 1) and src1 (tag 2) at the same edge:
  - `CDB_RR_EN` -> broadcasts tag 1 then tag 2 on consecutive cycles.
  - Fixed priority under continuous src0 pushes -> src1 waits until src0 drains.
- Hold src1_valid with the arbiter granting src0: after 2 accepted pushes src1_ready=0. It returns to 1 the cycle after its first grant. All values are broadcast in push order.
- Fill all FIFOs (6 entries), assert clear for one cycle -> next cycles cdb_valid=0, all src_ready=1, no stale tag is broadcast.
- Mid-stream drop rdy low for 3 cycles -> cdb outputs frozen, src_ready=0, FIFO contents intact. On rdy high, broadcasting resumes with no loss or duplication.
- Random valid traffic on all sources for 10k cycles (scoreboard) -> every accepted {tag, value} is broadcast exactly once, in per-source order.
  - `CDB_RR_EN`: no source waits more than NSRC grants once at its head.
